// File: rtl/text_overlay_pkg.sv
// Shared letter codes, message ids and per-message lengths for the text overlay.
package text_overlay_pkg;

  localparam logic [5:0] L_P = 6'd1;
  localparam logic [5:0] L_R = 6'd2;
  localparam logic [5:0] L_E = 6'd3;
  localparam logic [5:0] L_S = 6'd4;
  localparam logic [5:0] L_T = 6'd5;
  localparam logic [5:0] L_A = 6'd6;
  localparam logic [5:0] L_N = 6'd7;
  localparam logic [5:0] L_O = 6'd8;
  localparam logic [5:0] L_D = 6'd9;
  localparam logic [5:0] L_M = 6'd10;
  localparam logic [5:0] L_Y = 6'd11;
  localparam logic [5:0] L_U = 6'd12;
  localparam logic [5:0] L_W = 6'd13;
  localparam logic [5:0] L_I = 6'd14;
  localparam logic [5:0] L_L = 6'd15;
  localparam logic [5:0] CURSOR_CODE = 6'd63;

  typedef enum logic [2:0] {
    MSG_NONE   = 3'd0,
    MSG_START  = 3'd1,
    MSG_RANDOM = 3'd2,
    MSG_WIN    = 3'd3,
    MSG_LOSE   = 3'd4
  } msg_id_e;

  // Index of the last non-blank cell + 1; must track the contents of text_msg_rom.
  function automatic logic [8:0] msg_len(input logic [7:0] msg);
    case (msg)
      8'(MSG_START):  msg_len = 9'd27;
      8'(MSG_RANDOM): msg_len = 9'd38;
      8'(MSG_WIN):    msg_len = 9'd27;
      8'(MSG_LOSE):   msg_len = 9'd26;
      default:        msg_len = 9'd0;
    endcase
  endfunction

endpackage

// File: rtl/text_msg_rom.sv
// Message ROM: combinational lookup of the letter code at a cell of a message.
module text_msg_rom
  import text_overlay_pkg::*;
#(
  parameter int MSG_W  = 3,
  parameter int CODE_W = 6
) (
  input  logic [MSG_W-1:0]  msg,
  input  logic [7:0]        cell_idx,
  output logic [CODE_W-1:0] code
);

  always_comb begin
    code = '0;
    case ({8'(msg), cell_idx})
      {8'(MSG_START), 8'd16}:  code = CODE_W'(L_P);
      {8'(MSG_START), 8'd17}:  code = CODE_W'(L_R);
      {8'(MSG_START), 8'd18}:  code = CODE_W'(L_E);
      {8'(MSG_START), 8'd19}:  code = CODE_W'(L_S);
      {8'(MSG_START), 8'd20}:  code = CODE_W'(L_S);
      {8'(MSG_START), 8'd22}:  code = CODE_W'(L_S);
      {8'(MSG_START), 8'd23}:  code = CODE_W'(L_T);
      {8'(MSG_START), 8'd24}:  code = CODE_W'(L_A);
      {8'(MSG_START), 8'd25}:  code = CODE_W'(L_R);
      {8'(MSG_START), 8'd26}:  code = CODE_W'(L_T);
      {8'(MSG_RANDOM), 8'd32}: code = CODE_W'(L_R);
      {8'(MSG_RANDOM), 8'd33}: code = CODE_W'(L_A);
      {8'(MSG_RANDOM), 8'd34}: code = CODE_W'(L_N);
      {8'(MSG_RANDOM), 8'd35}: code = CODE_W'(L_D);
      {8'(MSG_RANDOM), 8'd36}: code = CODE_W'(L_O);
      {8'(MSG_RANDOM), 8'd37}: code = CODE_W'(L_M);
      {8'(MSG_WIN), 8'd20}:    code = CODE_W'(L_Y);
      {8'(MSG_WIN), 8'd21}:    code = CODE_W'(L_O);
      {8'(MSG_WIN), 8'd22}:    code = CODE_W'(L_U);
      {8'(MSG_WIN), 8'd24}:    code = CODE_W'(L_W);
      {8'(MSG_WIN), 8'd25}:    code = CODE_W'(L_I);
      {8'(MSG_WIN), 8'd26}:    code = CODE_W'(L_N);
      {8'(MSG_LOSE), 8'd18}:   code = CODE_W'(L_Y);
      {8'(MSG_LOSE), 8'd19}:   code = CODE_W'(L_O);
      {8'(MSG_LOSE), 8'd20}:   code = CODE_W'(L_U);
      {8'(MSG_LOSE), 8'd22}:   code = CODE_W'(L_L);
      {8'(MSG_LOSE), 8'd23}:   code = CODE_W'(L_O);
      {8'(MSG_LOSE), 8'd24}:   code = CODE_W'(L_S);
      {8'(MSG_LOSE), 8'd25}:   code = CODE_W'(L_E);
      default:                 code = '0;
    endcase
  end

endmodule

// File: rtl/text_overlay_mux.sv
// Pixel offset -> character cell -> letter code, 2-clock latency, one pixel per clock, no backpressure.
// Typewriter reveal per frame; TEXT_CURSOR_BLINK_EN adds a blinking cursor at the reveal point.
module text_overlay_mux
  import text_overlay_pkg::*;
#(
  parameter int CELL_W_LOG2   = 3,
  parameter int CELL_H_LOG2   = 4,
  parameter int COLS          = 16,
  parameter int ROWS          = 8,
  parameter int MSG_W         = 3,
  parameter int CODE_W        = 6,
  parameter int REVEAL_FRAMES = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [MSG_W-1:0]  msgSel,
  input  logic              startOfFrame,
  input  logic              insideRect,
  input  logic [10:0]       offsetX,
  input  logic [10:0]       offsetY,
  output logic [10:0]       outOffsetX,
  output logic [10:0]       outOffsetY,
  output logic [CODE_W-1:0] letter,
  output logic              letterValid,
  output logic              revealDone
);

  localparam int CNT_W = $clog2(COLS * ROWS + 1);
  localparam int FC_W  = (REVEAL_FRAMES > 1) ? $clog2(REVEAL_FRAMES) : 1;
  localparam int COL_W = 11 - CELL_W_LOG2;
  localparam int ROW_W = 11 - CELL_H_LOG2;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_REVEAL = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  logic [1:0]             state_q, state_d;
  logic [MSG_W-1:0]       cur_msg_q, cur_msg_d;
  logic [CNT_W-1:0]       reveal_cnt_q, reveal_cnt_d;
  logic [FC_W-1:0]        frame_cnt_q, frame_cnt_d;
  logic [CNT_W-1:0]       len_cur, len_sel, reveal_nxt;

  logic [COL_W-1:0]       col;
  logic [ROW_W-1:0]       row;
  logic                   in_range_q, in_range_d;
  logic [7:0]             cell_idx_q, cell_idx_d;
  logic [CELL_W_LOG2-1:0] off_x_lo_q, off_x_lo_d;
  logic [CELL_H_LOG2-1:0] off_y_lo_q, off_y_lo_d;

  logic [CODE_W-1:0]      rom_code;
  logic                   shown;
  logic [CODE_W-1:0]      letter_q, letter_d;
  logic                   letter_valid_q, letter_valid_d;
  logic [10:0]            out_off_x_q, out_off_x_d;
  logic [10:0]            out_off_y_q, out_off_y_d;

  assign len_cur    = CNT_W'(msg_len(8'(cur_msg_q)));
  assign len_sel    = CNT_W'(msg_len(8'(msgSel)));
  assign reveal_nxt = reveal_cnt_q + CNT_W'(1);

  // Message latch and reveal FSM; a message change outranks a reveal step.
  always_comb begin
    state_d      = state_q;
    cur_msg_d    = cur_msg_q;
    reveal_cnt_d = reveal_cnt_q;
    frame_cnt_d  = frame_cnt_q;
    if (startOfFrame) begin
      if (msgSel != cur_msg_q) begin
        cur_msg_d    = msgSel;
        reveal_cnt_d = '0;
        frame_cnt_d  = '0;
        if (msgSel == '0)        state_d = S_IDLE;
        else if (len_sel == '0)  state_d = S_DONE;
        else                     state_d = S_REVEAL;
      end else begin
        case (state_q)
          S_REVEAL: begin
            if (frame_cnt_q == FC_W'(REVEAL_FRAMES - 1)) begin
              frame_cnt_d = '0;
              if (reveal_cnt_q < len_cur) reveal_cnt_d = reveal_nxt;
              if (reveal_nxt >= len_cur)  state_d = S_DONE;
            end else begin
              frame_cnt_d = frame_cnt_q + FC_W'(1);
            end
          end
          S_IDLE, S_DONE: state_d = state_q;
          default:        state_d = S_IDLE;
        endcase
      end
    end
  end

  assign col = offsetX[10:CELL_W_LOG2];
  assign row = offsetY[10:CELL_H_LOG2];

  always_comb begin
    in_range_d = insideRect && (32'(col) < COLS) && (32'(row) < ROWS);
    cell_idx_d = 8'(32'(row) * 32'(COLS) + 32'(col));
    off_x_lo_d = offsetX[CELL_W_LOG2-1:0];
    off_y_lo_d = offsetY[CELL_H_LOG2-1:0];
  end

  text_msg_rom #(
    .MSG_W  (MSG_W),
    .CODE_W (CODE_W)
  ) u_rom (
    .msg      (cur_msg_q),
    .cell_idx (cell_idx_q),
    .code     (rom_code)
  );

  assign shown = in_range_q && (32'(cell_idx_q) < 32'(reveal_cnt_q));

`ifdef TEXT_CURSOR_BLINK_EN
  logic [4:0] blink_cnt_q, blink_cnt_d;
  logic       cursor_on;

  always_comb begin
    blink_cnt_d = blink_cnt_q;
    if (startOfFrame) blink_cnt_d = blink_cnt_q + 5'd1;
  end

  // In DONE revealCnt equals the message length, so the cursor lands after the last letter.
  assign cursor_on = blink_cnt_q[4] && (state_q != S_IDLE) && in_range_q &&
                     (32'(cell_idx_q) == 32'(reveal_cnt_q));

  always_ff @(posedge clk) begin
    if (reset) blink_cnt_q <= '0;
    else       blink_cnt_q <= blink_cnt_d;
  end
`endif

  always_comb begin
    letter_d = shown ? rom_code : '0;
`ifdef TEXT_CURSOR_BLINK_EN
    if (!shown && cursor_on) letter_d = CODE_W'(CURSOR_CODE);
`endif
    letter_valid_d = (letter_d != '0);
    out_off_x_d    = 11'(off_x_lo_q);
    out_off_y_d    = 11'(off_y_lo_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      cur_msg_q      <= '0;
      reveal_cnt_q   <= '0;
      frame_cnt_q    <= '0;
      in_range_q     <= 1'b0;
      cell_idx_q     <= '0;
      off_x_lo_q     <= '0;
      off_y_lo_q     <= '0;
      letter_q       <= '0;
      letter_valid_q <= 1'b0;
      out_off_x_q    <= '0;
      out_off_y_q    <= '0;
    end else begin
      state_q        <= state_d;
      cur_msg_q      <= cur_msg_d;
      reveal_cnt_q   <= reveal_cnt_d;
      frame_cnt_q    <= frame_cnt_d;
      in_range_q     <= in_range_d;
      cell_idx_q     <= cell_idx_d;
      off_x_lo_q     <= off_x_lo_d;
      off_y_lo_q     <= off_y_lo_d;
      letter_q       <= letter_d;
      letter_valid_q <= letter_valid_d;
      out_off_x_q    <= out_off_x_d;
      out_off_y_q    <= out_off_y_d;
    end
  end

  assign letter      = letter_q;
  assign letterValid = letter_valid_q;
  assign outOffsetX  = out_off_x_q;
  assign outOffsetY  = out_off_y_q;
  assign revealDone  = (state_q == S_DONE);

endmodule

// File: tb/tb_text_overlay_mux.sv
// Bench for text_overlay_mux: random pixels checked against a string-based model of the messages.
module tb_text_overlay_mux;

  localparam int RF = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  msgSel;
  logic        startOfFrame;
  logic        insideRect;
  logic [10:0] offsetX, offsetY;
  logic [10:0] outOffsetX, outOffsetY;
  logic [5:0]  letter;
  logic        letterValid;
  logic        revealDone;

  int checks = 0;
  int errors = 0;

  int m_cur, m_reveal, m_fc, m_frames;
  bit m_done;

  always #5 clk = ~clk;

  text_overlay_mux #(.REVEAL_FRAMES(RF)) dut (
    .clk          (clk),
    .reset        (reset),
    .msgSel       (msgSel),
    .startOfFrame (startOfFrame),
    .insideRect   (insideRect),
    .offsetX      (offsetX),
    .offsetY      (offsetY),
    .outOffsetX   (outOffsetX),
    .outOffsetY   (outOffsetY),
    .letter       (letter),
    .letterValid  (letterValid),
    .revealDone   (revealDone)
  );

  function automatic string msg_str(int m);
    case (m)
      1: return "PRESS START";
      2: return "RANDOM";
      3: return "YOU WIN";
      4: return "YOU LOSE";
      default: return "";
    endcase
  endfunction

  function automatic int msg_start(int m);
    case (m)
      1: return 16;
      2: return 32;
      3: return 20;
      4: return 18;
      default: return 0;
    endcase
  endfunction

  function automatic int char_code(byte c);
    case (c)
      "P": return 1;  "R": return 2;  "E": return 3;  "S": return 4;
      "T": return 5;  "A": return 6;  "N": return 7;  "O": return 8;
      "D": return 9;  "M": return 10; "Y": return 11; "U": return 12;
      "W": return 13; "I": return 14; "L": return 15;
      default: return 0;
    endcase
  endfunction

  function automatic int rom_model(int m, int idx);
    string s = msg_str(m);
    int st = msg_start(m);
    if (idx >= st && idx < st + s.len()) return char_code(s[idx - st]);
    return 0;
  endfunction

  function automatic int len_model(int m);
    string s = msg_str(m);
    return (s.len() == 0) ? 0 : msg_start(m) + s.len();
  endfunction

  function automatic logic [28:0] exp_pack(int x, int y, bit in);
    int col = x / 8;
    int row = y / 16;
    int idx = row * 16 + col;
    int code = 0;
    if (in && col < 16 && row < 8) begin
      if (idx < m_reveal) code = rom_model(m_cur, idx);
`ifdef TEXT_CURSOR_BLINK_EN
      else if (m_cur != 0 && idx == m_reveal && ((m_frames >> 4) & 1) == 1) code = 63;
`endif
    end
    return {6'(code), (code != 0), 11'(x % 8), 11'(y % 16)};
  endfunction

  task automatic model_reset();
    m_cur = 0; m_reveal = 0; m_fc = 0; m_frames = 0; m_done = 0;
  endtask

  task automatic model_pulse(int sel);
    m_frames++;
    if (sel != m_cur) begin
      m_cur = sel; m_reveal = 0; m_fc = 0;
      m_done = (sel != 0 && len_model(sel) == 0);
    end else if (m_cur != 0 && !m_done) begin
      if (m_fc == RF - 1) begin
        m_fc = 0;
        m_reveal++;
        if (m_reveal >= len_model(m_cur)) m_done = 1;
      end else begin
        m_fc++;
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drive_pixel(int x, int y, bit in);
    offsetX = 11'(x); offsetY = 11'(y); insideRect = in;
  endtask

  task automatic pixel_wait(int x, int y, bit in);
    drive_pixel(x, y, in);
    tick();
    tick();
  endtask

  task automatic pulse();
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
    model_pulse(int'(msgSel));
  endtask

  task automatic test_reset();
    logic [28:0] got, want;
    int x, y;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      msgSel = 3'($urandom_range(0, 7));
      startOfFrame = 1'($urandom_range(0, 1));
      insideRect = 1'b1;
      offsetX = 11'($urandom_range(0, 2047));
      offsetY = 11'($urandom_range(0, 2047));
      tick();
    end
    got = {letter, letterValid, outOffsetX, outOffsetY};
    checks++;
    if (got !== 29'd0 || revealDone !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %h done %b, required 0 done 0", got, revealDone);
    end
    reset = 1'b0; msgSel = 3'd0; startOfFrame = 1'b0;
    model_reset();
    for (int i = 0; i < 20; i++) begin
      if (i % 5 == 4) pulse();
      x = $urandom_range(0, 140); y = $urandom_range(0, 140);
      pixel_wait(x, y, 1'b1);
      got  = {letter, letterValid, outOffsetX, outOffsetY};
      want = {6'd0, 1'b0, 11'(x % 8), 11'(y % 16)};
      checks++;
      if (got !== want || revealDone !== 1'b0) begin
        errors++;
        $display("FAIL idle_blank: got %h done %b, required %h done 0", got, revealDone, want);
      end
    end
  endtask

  task automatic test_pixel_path();
    logic [28:0] got, want;
    int n, x, y;
    msgSel = 3'd1;
    pulse();
    n = 0;
    while (revealDone !== 1'b1 && n < 300) begin
      pulse();
      n++;
    end
    checks++;
    if (revealDone !== 1'b1) begin
      errors++;
      $display("FAIL pixel_path_done_timeout: revealDone %b after %0d frames, required 1", revealDone, n);
    end
    pixel_wait(9, 17, 1'b1);
    got = {letter, letterValid, outOffsetX, outOffsetY};
    checks++;
    if (got !== {6'd2, 1'b1, 11'd1, 11'd1}) begin
      errors++;
      $display("FAIL pixel_path_cell17: got %h, required %h", got, {6'd2, 1'b1, 11'd1, 11'd1});
    end
    for (int i = 0; i < 30; i++) begin
      x = $urandom_range(0, 127); y = $urandom_range(0, 127);
      pixel_wait(x, y, 1'b1);
      got = {letter, letterValid, outOffsetX, outOffsetY};
      want = exp_pack(x, y, 1'b1);
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL pixel_path_random (%0d,%0d): got %h, required %h", x, y, got, want);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [28:0] q[$];
    logic [28:0] got, want;
    int x, y;
    bit in;
    for (int i = 0; i <= 200; i++) begin
      if (i < 200) begin
        x = $urandom_range(0, 160); y = $urandom_range(0, 150); in = 1'($urandom_range(0, 7) != 0);
        drive_pixel(x, y, in);
        q.push_back(exp_pack(x, y, in));
      end else begin
        drive_pixel(0, 0, 1'b0);
      end
      tick();
      if (i >= 1) begin
        want = q.pop_front();
        got = {letter, letterValid, outOffsetX, outOffsetY};
        checks++;
        if (got !== want) begin
          errors++;
          $display("FAIL back_to_back[%0d]: got %h, required %h", i - 1, got, want);
        end
      end
    end
  endtask

  task automatic test_reveal_timing();
    logic [28:0] got, want;
    msgSel = 3'd3;
    pulse();
    checks++;
    if (revealDone !== 1'b0) begin
      errors++;
      $display("FAIL reveal_change_clears: revealDone %b, required 0", revealDone);
    end
    for (int k = 1; k <= 108; k++) begin
      pulse();
      checks++;
      if (revealDone !== 1'(k == 108)) begin
        errors++;
        $display("FAIL reveal_done frame %0d: revealDone %b, required %b", k, revealDone, (k == 108));
      end
      if (k == 83 || k == 84) begin
        pixel_wait(33, 18, 1'b1);
        got = {letter, letterValid, outOffsetX, outOffsetY};
        want = (k == 84) ? {6'd11, 1'b1, 11'd1, 11'd2} : exp_pack(33, 18, 1'b1);
        checks++;
        if (got !== want || (k == 83 && letter === 6'd11)) begin
          errors++;
          $display("FAIL reveal_cell20 frame %0d: got %h, required %h", k, got, want);
        end
      end
    end
  endtask

  task automatic test_boundary();
    int bx[5] = '{128, 33, 33, 2047, 33};
    int by[5] = '{18, 128, 18, 2047, 18};
    bit bin[5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [28:0] got, want;
    for (int i = 0; i < 5; i++) begin
      pixel_wait(bx[i], by[i], bin[i]);
      got = {letter, letterValid, outOffsetX, outOffsetY};
      want = {(i == 4) ? 6'd11 : 6'd0, 1'(i == 4), 11'(bx[i] % 8), 11'(by[i] % 16)};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL boundary (%0d,%0d,in=%0d): got %h, required %h", bx[i], by[i], bin[i], got, want);
      end
    end
  endtask

  task automatic test_mid_frame_change();
    logic [28:0] got;
    msgSel = 3'd4;
    tick(); tick(); tick();
    pixel_wait(33, 18, 1'b1);
    got = {letter, letterValid, outOffsetX, outOffsetY};
    checks++;
    if (got !== {6'd11, 1'b1, 11'd1, 11'd2} || revealDone !== 1'b1) begin
      errors++;
      $display("FAIL mid_frame_hold: got %h done %b, required %h done 1", got, revealDone, {6'd11, 1'b1, 11'd1, 11'd2});
    end
    pulse();
    checks++;
    if (revealDone !== 1'b0) begin
      errors++;
      $display("FAIL mid_frame_done_drop: revealDone %b, required 0", revealDone);
    end
    pixel_wait(33, 18, 1'b1);
    got = {letter, letterValid, outOffsetX, outOffsetY};
    checks++;
    if (got !== {6'd0, 1'b0, 11'd1, 11'd2}) begin
      errors++;
      $display("FAIL mid_frame_new_msg_blank: got %h, required %h", got, {6'd0, 1'b0, 11'd1, 11'd2});
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [28:0] got, want;
    for (int k = 0; k < 80; k++) pulse();
    pixel_wait(17, 18, 1'b1);
    got = {letter, letterValid, outOffsetX, outOffsetY};
    want = exp_pack(17, 18, 1'b1);
    checks++;
    if (got !== want || letter !== 6'd11) begin
      errors++;
      $display("FAIL pre_reset_letter: got %h, required %h", got, want);
    end
    drive_pixel(17, 18, 1'b1);
    tick();
    reset = 1'b1;
    tick();
    got = {letter, letterValid, outOffsetX, outOffsetY};
    checks++;
    if (got !== 29'd0 || revealDone !== 1'b0) begin
      errors++;
      $display("FAIL reset_flush: got %h done %b, required 0 done 0", got, revealDone);
    end
    reset = 1'b0;
    model_reset();
    pixel_wait(17, 18, 1'b1);
    got = {letter, letterValid, outOffsetX, outOffsetY};
    checks++;
    if (got !== {6'd0, 1'b0, 11'd1, 11'd2} || revealDone !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_idle: got %h done %b, required %h done 0", got, revealDone, {6'd0, 1'b0, 11'd1, 11'd2});
    end
    pulse();
    pixel_wait(17, 18, 1'b1);
    got = {letter, letterValid, outOffsetX, outOffsetY};
    want = exp_pack(17, 18, 1'b1);
    checks++;
    if (got !== want || revealDone !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_restart: got %h done %b, required %h done 0", got, revealDone, want);
    end
  endtask

  task automatic test_cursor();
    int idx, want_code;
    msgSel = 3'd2;
    pulse();
    for (int k = 0; k < 40; k++) begin
      pulse();
      idx = m_reveal;
      pixel_wait((idx % 16) * 8 + 3, (idx / 16) * 16 + 5, 1'b1);
      want_code = 0;
`ifdef TEXT_CURSOR_BLINK_EN
      if (((m_frames >> 4) & 1) == 1) want_code = 63;
`endif
      checks++;
      if (letter !== 6'(want_code) || letterValid !== (want_code != 0)) begin
        errors++;
        $display("FAIL cursor_cell frame %0d idx %0d: letter %0d valid %b, required %0d", m_frames, idx, letter, letterValid, want_code);
      end
    end
  endtask

  initial begin
    reset = 1'b1; msgSel = 3'd0; startOfFrame = 1'b0; insideRect = 1'b0;
    offsetX = 11'd0; offsetY = 11'd0;
    model_reset();
    tick();
    test_reset();
    test_pixel_path();
    test_back_to_back();
    test_reveal_timing();
    test_boundary();
    test_mid_frame_change();
    test_reset_mid_frame();
    test_cursor();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
